// File: rtl/ei_tdp_ram_arb_pkg.sv
// Shared defaults, response tag and port selector types for the TDP RAM port arbiter.
package ei_tdp_ram_arb_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned REQ_IDX_W      = $clog2(DEF_NUM_REQ);

    // Tag index is sized for the largest supported requester count (8).
    localparam int unsigned MAX_NUM_REQ    = 8;
    localparam int unsigned TAG_IDX_W      = $clog2(MAX_NUM_REQ);

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } rsp_tag_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

endpackage

// File: rtl/ei_tdp_ram_rr_picker.sv
// Round-robin picker: first and second valid requesters scanning upward from rr_ptr.
module ei_tdp_ram_rr_picker
    import ei_tdp_ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = REQ_IDX_W
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               first_found_c,
    output logic [IDX_W-1:0]   first_idx_c,
    output logic               second_found_c,
    output logic [IDX_W-1:0]   second_idx_c
);

    logic [IDX_W-1:0] idx;

    // NUM_REQ is a power of two, so the IDX_W-bit add wraps modulo NUM_REQ.
    always_comb begin
        first_found_c  = 1'b0;
        first_idx_c    = '0;
        second_found_c = 1'b0;
        second_idx_c   = '0;
        idx            = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr + IDX_W'(k);
            if (valid[idx]) begin
                if (!first_found_c) begin
                    first_found_c = 1'b1;
                    first_idx_c   = idx;
                end else if (!second_found_c) begin
                    second_found_c = 1'b1;
                    second_idx_c   = idx;
                end
            end
        end
    end

endmodule

// File: rtl/ei_tdp_ram_port_arbiter.sv
// Shares the two ports of a true-dual-port RAM among NUM_REQ requesters,
// granting up to two requests per cycle round-robin and routing read data back.
module ei_tdp_ram_port_arbiter
    import ei_tdp_ram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata,
    output logic                          we_a,
    output logic                          re_a,
    output logic                          we_b,
    output logic                          re_b,
    output logic [ADDR_WIDTH-1:0]         addr_a,
    output logic [ADDR_WIDTH-1:0]         addr_b,
    output logic [DATA_WIDTH-1:0]         data_a,
    output logic [DATA_WIDTH-1:0]         data_b,
    input  logic [DATA_WIDTH-1:0]         out_a,
    input  logic [DATA_WIDTH-1:0]         out_b,
    output logic [15:0]                   collision_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]              rr_ptr;
    logic [IDX_W-1:0]              rr_ptr_nxt;
    logic [IDX_W-1:0]              a_idx;
    logic [IDX_W-1:0]              b_idx;
    logic                          a_found;
    logic                          b_found;
    logic                          grant_a;
    logic                          grant_b;
    logic                          hazard;
    logic [ADDR_WIDTH-1:0]         a_addr;
    logic [ADDR_WIDTH-1:0]         b_addr;
    logic [DATA_WIDTH-1:0]         a_wdata;
    logic [DATA_WIDTH-1:0]         b_wdata;
    logic                          a_we;
    logic                          b_we;
    rsp_tag_t                      tag_s1 [2];
    rsp_tag_t                      tag_s2 [2];
    logic [NUM_REQ*DATA_WIDTH-1:0] rdata_q;

    ei_tdp_ram_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid          (req_valid),
        .rr_ptr         (rr_ptr),
        .first_found_c  (a_found),
        .first_idx_c    (a_idx),
        .second_found_c (b_found),
        .second_idx_c   (b_idx)
    );

    assign a_addr  = req_addr[a_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign b_addr  = req_addr[b_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign a_wdata = req_wdata[a_idx*DATA_WIDTH +: DATA_WIDTH];
    assign b_wdata = req_wdata[b_idx*DATA_WIDTH +: DATA_WIDTH];
    assign a_we    = req_we[a_idx];
    assign b_we    = req_we[b_idx];

    // Grant A unconditionally; defer B when it hits A's address and either side writes.
    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        hazard     = 1'b0;
        req_ready  = '0;
        rr_ptr_nxt = rr_ptr;
        if (en && resetn && a_found) begin
            grant_a           = 1'b1;
            req_ready[a_idx]  = 1'b1;
            rr_ptr_nxt        = a_idx + IDX_W'(1);
            if (b_found) begin
                hazard = (a_addr == b_addr) && (a_we || b_we);
                if (!hazard) begin
                    grant_b          = 1'b1;
                    req_ready[b_idx] = 1'b1;
                    rr_ptr_nxt       = b_idx + IDX_W'(1);
                end
            end
        end
    end

    // RAM port command registers; idle ports keep their last address and data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we_a          <= 1'b0;
            re_a          <= 1'b0;
            we_b          <= 1'b0;
            re_b          <= 1'b0;
            addr_a        <= '0;
            addr_b        <= '0;
            data_a        <= '0;
            data_b        <= '0;
            rr_ptr        <= '0;
            collision_cnt <= '0;
        end else begin
            we_a   <= grant_a && a_we;
            re_a   <= grant_a && !a_we;
            we_b   <= grant_b && b_we;
            re_b   <= grant_b && !b_we;
            rr_ptr <= rr_ptr_nxt;
            if (grant_a) addr_a <= a_addr;
            if (grant_a && a_we) data_a <= a_wdata;
            if (grant_b) addr_b <= b_addr;
            if (grant_b && b_we) data_b <= b_wdata;
            if (hazard && (collision_cnt != 16'hFFFF)) collision_cnt <= collision_cnt + 16'd1;
        end
    end

    // Read tags travel alongside the command, aligning with out_x two cycles after grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_s1[PORT_A] <= '0;
            tag_s1[PORT_B] <= '0;
            tag_s2[PORT_A] <= '0;
            tag_s2[PORT_B] <= '0;
            rdata_q        <= '0;
        end else begin
            tag_s1[PORT_A] <= '{valid: grant_a && !a_we, idx: TAG_IDX_W'(a_idx)};
            tag_s1[PORT_B] <= '{valid: grant_b && !b_we, idx: TAG_IDX_W'(b_idx)};
            tag_s2[PORT_A] <= tag_s1[PORT_A];
            tag_s2[PORT_B] <= tag_s1[PORT_B];
            rdata_q        <= rsp_rdata;
        end
    end

    // Responding slices pass out_x through; all others show the last captured data.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = rdata_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (tag_s2[PORT_A].valid && (tag_s2[PORT_A].idx == TAG_IDX_W'(i))) begin
                rsp_valid[i]                          = 1'b1;
                rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = out_a;
            end
            if (tag_s2[PORT_B].valid && (tag_s2[PORT_B].idx == TAG_IDX_W'(i))) begin
                rsp_valid[i]                          = 1'b1;
                rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = out_b;
            end
        end
    end

endmodule

// File: tb/tb_ei_tdp_ram_port_arbiter.sv
// Randomised scoreboard bench for ei_tdp_ram_port_arbiter with a behavioural RAM and arbiter model.
`timescale 1ns/1ps
module tb_ei_tdp_ram_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             en = 1'b0;
    logic [NR-1:0]    r_valid;
    logic [NR-1:0]    r_we;
    logic [AW-1:0]    r_addr [NR];
    logic [DW-1:0]    r_wdata [NR];
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [NR*DW-1:0] rsp_rdata;
    logic             we_a, re_a, we_b, re_b;
    logic [AW-1:0]    addr_a, addr_b;
    logic [DW-1:0]    data_a, data_b;
    logic [DW-1:0]    out_a = '0;
    logic [DW-1:0]    out_b = '0;
    logic [15:0]      collision_cnt;

    ei_tdp_ram_port_arbiter dut (
        .clk           (clk),
        .resetn        (resetn),
        .en            (en),
        .req_valid     (r_valid),
        .req_we        (r_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .we_a          (we_a),
        .re_a          (re_a),
        .we_b          (we_b),
        .re_b          (re_b),
        .addr_a        (addr_a),
        .addr_b        (addr_b),
        .data_a        (data_a),
        .data_b        (data_b),
        .out_a         (out_a),
        .out_b         (out_b),
        .collision_cnt (collision_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = r_addr[i];
            req_wdata[i*DW +: DW] = r_wdata[i];
        end
    end

    // Synchronous true-dual-port RAM: read data appears the cycle after re_x is sampled.
    logic [DW-1:0] mem [1<<AW];
    always @(posedge clk) begin
        if (re_a) out_a <= mem[addr_a];
        if (re_b) out_b <= mem[addr_b];
        if (we_a) mem[addr_a] = data_a;
        if (we_b) mem[addr_b] = data_b;
    end

    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } exp_rsp_t;

    typedef struct packed {
        logic          we_a;
        logic          re_a;
        logic [AW-1:0] addr_a;
        logic [DW-1:0] data_a;
        logic          we_b;
        logic          re_b;
        logic [AW-1:0] addr_b;
        logic [DW-1:0] data_b;
    } port_t;

    logic [DW-1:0] ref_mem [1<<AW];
    exp_rsp_t      rsp_q [$];
    port_t         exp_port;
    logic [NR*DW-1:0] held;
    logic [NR-1:0] acc;
    int            m_rr;
    logic [15:0]   m_coll;
    int            rsp_count [NR];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor and reference model: compare DUT against expectations, then advance the model.
    always @(negedge clk) begin : monitor
        port_t         dut_port;
        port_t         nx;
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] exp_valid;
        exp_rsp_t      e;
        int            first;
        int            second;
        int            j;
        bit            haz;
        dut_port = {we_a, re_a, addr_a, data_a, we_b, re_b, addr_b, data_b};
        if (!resetn) begin
            chk("reset_ready", 64'(req_ready), 64'(0));
            chk("reset_ports", 64'(dut_port), 64'(0));
            chk("reset_rsp", 64'({rsp_valid, rsp_rdata}), 64'(0));
            chk("reset_coll", 64'(collision_cnt), 64'(0));
            rsp_q.delete();
            m_rr     = 0;
            m_coll   = '0;
            exp_port = '0;
            held     = '0;
            acc      = '0;
        end else begin
            chk("port_cmd", 64'(dut_port), 64'(exp_port));
            exp_valid = '0;
            while (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                e = rsp_q.pop_front();
                exp_valid[e.idx]      = 1'b1;
                held[e.idx*DW +: DW]  = e.data;
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(held));
            for (int i = 0; i < NR; i++) if (rsp_valid[i]) rsp_count[i]++;

            first = -1; second = -1; haz = 1'b0; exp_ready = '0;
            if (en) begin
                for (int k = 0; k < NR; k++) begin
                    j = (m_rr + k) % NR;
                    if (r_valid[j]) begin
                        if (first < 0) first = j;
                        else if (second < 0) second = j;
                    end
                end
            end
            if (first >= 0) begin
                exp_ready[first] = 1'b1;
                if (second >= 0) begin
                    haz = (r_addr[first] == r_addr[second]) && (r_we[first] || r_we[second]);
                    if (haz) second = -1;
                    else exp_ready[second] = 1'b1;
                end
            end
            chk("collision_cnt", 64'(collision_cnt), 64'(m_coll));
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            if (haz && m_coll != 16'hFFFF) m_coll = m_coll + 16'd1;

            nx = exp_port;
            nx.we_a = 1'b0; nx.re_a = 1'b0; nx.we_b = 1'b0; nx.re_b = 1'b0;
            if (first >= 0) begin
                nx.addr_a = r_addr[first];
                if (r_we[first]) begin
                    nx.we_a = 1'b1;
                    nx.data_a = r_wdata[first];
                    ref_mem[r_addr[first]] = r_wdata[first];
                end else begin
                    nx.re_a = 1'b1;
                    rsp_q.push_back('{cyc + 2, first, ref_mem[r_addr[first]]});
                end
                m_rr = (first + 1) % NR;
            end
            if (second >= 0) begin
                nx.addr_b = r_addr[second];
                if (r_we[second]) begin
                    nx.we_b = 1'b1;
                    nx.data_b = r_wdata[second];
                    ref_mem[r_addr[second]] = r_wdata[second];
                end else begin
                    nx.re_b = 1'b1;
                    rsp_q.push_back('{cyc + 2, second, ref_mem[r_addr[second]]});
                end
                m_rr = (second + 1) % NR;
            end
            exp_port = nx;
            acc = r_valid & req_ready;
        end
    end

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        r_valid[i] = 1'b1;
        r_we[i]    = we;
        r_addr[i]  = addr;
        r_wdata[i] = wd;
    endtask

    // One clock: requesters drop requests that were accepted in the previous cycle.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (acc[i]) r_valid[i] = 1'b0;
    endtask

    task automatic run_idle(input int max);
        int c;
        c = 0;
        while (r_valid != '0 && c < max) begin
            step();
            c++;
        end
        chk("idle_timeout", 64'(r_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base [NR];
        r_valid = '0;
        r_we    = '0;
        for (int i = 0; i < NR; i++) begin
            r_addr[i]    = '0;
            r_wdata[i]   = '0;
            rsp_count[i] = 0;
        end
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[5]     = 8'h3C;
        ref_mem[5] = 8'h3C;
        en     = 1'b1;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Single read, dual issue, then a same-address write/read collision.
        set_req(0, 1'b0, 10'h005, 8'h00);
        run_idle(10);
        set_req(1, 1'b1, 10'h010, 8'hAA);
        set_req(2, 1'b0, 10'h020, 8'h00);
        run_idle(10);
        set_req(0, 1'b1, 10'h040, 8'h11);
        set_req(1, 1'b0, 10'h040, 8'h00);
        run_idle(10);
        repeat (3) step();
        chk("collision_after_pair", 64'(collision_cnt), 64'(1));

        // Fairness: every requester reads continuously for eight cycles.
        for (int i = 0; i < NR; i++) base[i] = rsp_count[i];
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(16 * i + c), 8'h00);
            step();
        end
        r_valid = '0;
        repeat (3) step();
        for (int i = 0; i < NR; i++) chk($sformatf("fair_rsp_%0d", i), 64'(rsp_count[i] - base[i]), 64'(4));

        // Disabled arbitration holds off a pending request until en rises.
        en = 1'b0;
        set_req(3, 1'b0, 10'h077, 8'h00);
        repeat (3) step();
        chk("en0_pending", 64'(r_valid[3]), 64'(1));
        en = 1'b1;
        run_idle(5);
        repeat (3) step();

        // Reset in the cycle after a read is accepted drops its response.
        set_req(0, 1'b0, 10'h005, 8'h00);
        step();
        resetn = 1'b0;
        r_valid = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (4) step();

        // Randomised traffic over a small address window to provoke collisions.
        for (int c = 0; c < 1500; c++) begin
            step();
            en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NR; i++) begin
                if (!r_valid[i] && $urandom_range(0, 3) != 0)
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 8'($urandom));
            end
        end
        step();
        r_valid = '0;
        en = 1'b1;
        repeat (4) step();
        chk("drain_queue", 64'(rsp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
